rap_err_monitor: RTL and testbench
==================================

RAP_ERR_MONITOR -- requirements
Module: rap_err_monitor

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width of the monitored approximate adder.
REQ-002 SHALL have parameter N_SAMPLES, default 1024, samples per measurement run (1..2^32-1).
REQ-003 SHALL have one clock and a synchronous, active-high reset.
REQ-004 Ports: clk  in  1  sole clock; all logic on rising edge.
REQ-005 Ports: rst  in  1  synchronous active-high reset.
REQ-006 Ports: start  in  1  begin run; clears statistics.
REQ-007 Ports: clear  in  1  abort or close run; return to IDLE.
REQ-008 Ports: valid_in  in  1  sample strobe.
REQ-009 Ports: a, b  in  WIDTH  operands fed to the approximate adder.
REQ-010 Ports: approx_sum  in  WIDTH+1  adder result for a, b.
REQ-011 Ports: busy  out  1  state RUN.
REQ-012 Ports: done  out  1  state DONE; statistics final.
REQ-013 Ports: sample_cnt  out  32  samples committed.
REQ-014 Ports: err_cnt  out  32  samples with nonzero error distance.
REQ-015 Ports: ed_sum  out  48  sum of error distances.
REQ-016 Ports: ed_max  out  WIDTH+1  largest error distance seen.

Function
REQ-017 States: IDLE, RUN, DONE; IDLE->RUN on start; RUN->DONE after last sample commits; any state->IDLE on clear.
REQ-018 clear SHALL take priority over start in the same cycle; the pipeline is flushed and statistics are zeroed.
REQ-019 start in IDLE or DONE SHALL zero all statistics and the accept counter in that cycle; start in RUN is ignored.
REQ-020 Stage 1 SHALL capture a sample when valid_in=1, state=RUN, and the accept counter is below N_SAMPLES; the accept counter increments on capture.
REQ-021 valid_in SHALL be ignored in IDLE, in DONE, and once N_SAMPLES samples are accepted.
REQ-022 Stage 1 SHALL compute exact=a+b (WIDTH+1 bits, no truncation) and ed=|exact-approx_sum| as an unsigned value.
REQ-023 Stage 2 SHALL commit the captured sample one cycle later: sample_cnt+=1; err_cnt+=1 if ed!=0; ed_sum+=ed, saturating at 2^48-1; ed_max=max(ed_max,ed).
REQ-024 Latency: a sample accepted at edge t SHALL be visible on the outputs after edge t+2.
REQ-025 done SHALL rise on the edge after the N_SAMPLES-th commit, and all statistics SHALL then hold until start, clear, or rst.
REQ-026 sample_cnt and err_cnt SHALL saturate at 2^32-1.
REQ-027 The block SHALL accept back-to-back valid_in every cycle without loss (no backpressure).

Reset
REQ-028 rst SHALL force state IDLE, clear both pipeline valid bits, and clear the accept counter.
REQ-029 On rst: busy=0, done=0, sample_cnt=0, err_cnt=0, ed_sum=0, ed_max=0.
REQ-030 rst during RUN SHALL discard all in-flight samples; none commits after reset.

Structure
REQ-031 Shared package rap_mon_pkg SHALL hold the state enum, the ED_SUM_W=48 and CNT_W=32 constants, and saturating-add helpers.
REQ-032 One sub-module rap_ed_calc SHALL hold the combinational exact-sum and absolute-distance logic (inputs a, b, approx_sum; output ed); all state and registers stay in rap_err_monitor.

Verification
REQ-033 Exact sample: rst, start, then valid_in with a=0xFF, b=0x01, approx_sum=0x100; with N_SAMPLES=1, two cycles later sample_cnt=1, err_cnt=0, ed_sum=0, ed_max=0, and done=1 after the next edge.
REQ-034 Error sample: a=0xFFFFFFFF, b=0x1, approx_sum=0x0FFFFFF00 -> ed=0x100; err_cnt=1, ed_sum=0x100, ed_max=0x100.
REQ-035 Back-to-back: N_SAMPLES=4, valid_in held for 6 cycles with ed values 1,5,2,0,9,9 -> sample_cnt=4, err_cnt=3, ed_sum=8, ed_max=5; last two samples ignored; done=1.
REQ-036 Priority and abort: start and clear asserted together -> state IDLE, all stats 0; rst asserted one cycle after an accepted sample -> sample_cnt stays 0.
REQ-037 Saturation: ed_sum preloaded near full by force, or run with ed=2^32 for 2^16+1 samples -> ed_sum=0xFFFFFFFFFFFF, with no wrap.

Source files
------------

// File: rtl/rap_mon_pkg.sv
// Shared types and helpers for the approximate-adder error monitor.
// Holds the run FSM encoding, counter widths and saturating adders.
package rap_mon_pkg;

    localparam int ED_SUM_W = 48;
    localparam int CNT_W    = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc_cnt(
        input logic [CNT_W-1:0] v
    );
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [ED_SUM_W-1:0] sat_add_sum(
        input logic [ED_SUM_W-1:0] s,
        input logic [ED_SUM_W-1:0] d
    );
        logic [ED_SUM_W:0] t;
        t = {1'b0, s} + {1'b0, d};
        return t[ED_SUM_W] ? {ED_SUM_W{1'b1}} : t[ED_SUM_W-1:0];
    endfunction

endpackage

// File: rtl/rap_ed_calc.sv
// Exact sum of the operands and its unsigned distance to the
// approximate adder result; purely combinational.
module rap_ed_calc
    import rap_mon_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH:0]   approx_sum,
    output logic [WIDTH:0]   ed
);

    logic [WIDTH:0] w_exact;

    assign w_exact = {1'b0, a} + {1'b0, b};

    always_comb begin
        ed = '0;
        if (w_exact >= approx_sum) begin
            ed = w_exact - approx_sum;
        end else begin
            ed = approx_sum - w_exact;
        end
    end

endmodule

// File: rtl/rap_err_monitor.sv
// Error statistics monitor for an approximate adder: two-stage
// pipeline (capture/distance, commit) driven by an IDLE/RUN/DONE FSM.
module rap_err_monitor
    import rap_mon_pkg::*;
#(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [CNT_W-1:0] N_SAMPLES = 32'd1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                clear,
    input  logic                valid_in,
    input  logic [WIDTH-1:0]    a,
    input  logic [WIDTH-1:0]    b,
    input  logic [WIDTH:0]      approx_sum,
    output logic                busy,
    output logic                done,
    output logic [CNT_W-1:0]    sample_cnt,
    output logic [CNT_W-1:0]    err_cnt,
    output logic [ED_SUM_W-1:0] ed_sum,
    output logic [WIDTH:0]      ed_max
);

    state_t r_state;
    state_t w_next_state;

    logic [CNT_W-1:0]    r_acc_cnt;
    logic                r_s1_vld;
    logic [WIDTH-1:0]    r_s1_a;
    logic [WIDTH-1:0]    r_s1_b;
    logic [WIDTH:0]      r_s1_sum;
    logic [WIDTH:0]      w_s1_ed;
    logic                r_s2_vld;
    logic [WIDTH:0]      r_s2_ed;
    logic [CNT_W-1:0]    r_sample_cnt;
    logic [CNT_W-1:0]    r_err_cnt;
    logic [ED_SUM_W-1:0] r_ed_sum;
    logic [WIDTH:0]      r_ed_max;

    logic w_accept;
    logic w_restart;

    // clear wins over both start and an incoming sample
    assign w_accept  = valid_in && !clear && (r_state == ST_RUN)
                       && (r_acc_cnt < N_SAMPLES);
    assign w_restart = start && !clear && (r_state != ST_RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_IDLE: if (start) w_next_state = ST_RUN;
            ST_RUN:  if (r_sample_cnt == N_SAMPLES) w_next_state = ST_DONE;
            ST_DONE: if (start) w_next_state = ST_RUN;
            default: w_next_state = ST_IDLE;
        endcase
        if (clear) begin
            w_next_state = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_s1_vld <= 1'b0;
            r_s2_vld <= 1'b0;
        end else begin
            r_s1_vld <= w_accept;
            r_s2_vld <= r_s1_vld;
        end
    end

    // operand/result registers carry no reset; the valid bits gate them
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_s1_a   <= a;
            r_s1_b   <= b;
            r_s1_sum <= approx_sum;
        end
        if (r_s1_vld) begin
            r_s2_ed <= w_s1_ed;
        end
    end

    rap_ed_calc #(
        .WIDTH(WIDTH)
    ) u_ed_calc (
        .a          (r_s1_a),
        .b          (r_s1_b),
        .approx_sum (r_s1_sum),
        .ed         (w_s1_ed)
    );

    always_ff @(posedge clk) begin
        if (rst || clear || w_restart) begin
            r_acc_cnt    <= '0;
            r_sample_cnt <= '0;
            r_err_cnt    <= '0;
            r_ed_sum     <= '0;
            r_ed_max     <= '0;
        end else begin
            if (w_accept) begin
                r_acc_cnt <= r_acc_cnt + CNT_W'(1);
            end
            if (r_s2_vld) begin
                r_sample_cnt <= sat_inc_cnt(r_sample_cnt);
                if (r_s2_ed != '0) begin
                    r_err_cnt <= sat_inc_cnt(r_err_cnt);
                end
                r_ed_sum <= sat_add_sum(r_ed_sum, ED_SUM_W'(r_s2_ed));
                if (r_s2_ed > r_ed_max) begin
                    r_ed_max <= r_s2_ed;
                end
            end
        end
    end

    assign busy       = (r_state == ST_RUN);
    assign done       = (r_state == ST_DONE);
    assign sample_cnt = r_sample_cnt;
    assign err_cnt    = r_err_cnt;
    assign ed_sum     = r_ed_sum;
    assign ed_max     = r_ed_max;

endmodule

// File: tb/tb_rap_err_monitor.sv
// Directed bench for rap_err_monitor: single-sample vector table plus
// back-to-back, priority, abort and saturation sequences.
module tb_rap_err_monitor;

    localparam int W = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         start;
    logic         clear;
    logic         valid_in;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W:0]   approx_sum;

    logic        busy1, done1, busy4, done4, busys, dones;
    logic [31:0] sc1, ec1, sc4, ec4, scs, ecs;
    logic [47:0] es1, es4, ess;
    logic [W:0]  em1, em4, ems;

    int n_cmp = 0;
    int n_bad = 0;

    rap_err_monitor #(.WIDTH(W), .N_SAMPLES(32'd1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .clear(clear),
        .valid_in(valid_in), .a(a), .b(b), .approx_sum(approx_sum),
        .busy(busy1), .done(done1), .sample_cnt(sc1), .err_cnt(ec1),
        .ed_sum(es1), .ed_max(em1)
    );

    rap_err_monitor #(.WIDTH(W), .N_SAMPLES(32'd4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start), .clear(clear),
        .valid_in(valid_in), .a(a), .b(b), .approx_sum(approx_sum),
        .busy(busy4), .done(done4), .sample_cnt(sc4), .err_cnt(ec4),
        .ed_sum(es4), .ed_max(em4)
    );

    rap_err_monitor #(.WIDTH(W), .N_SAMPLES(32'd65537)) u_duts (
        .clk(clk), .rst(rst), .start(start), .clear(clear),
        .valid_in(valid_in), .a(a), .b(b), .approx_sum(approx_sum),
        .busy(busys), .done(dones), .sample_cnt(scs), .err_cnt(ecs),
        .ed_sum(ess), .ed_max(ems)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W:0]   ap;
        logic [W:0]   ed;
    } vec_t;

    vec_t tbl [8];
    int   eds [6];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic restart();
        clear = 1'b1;
        cyc(1);
        clear = 1'b0;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{32'hFF, 32'h1, 33'h100, 33'h0};
        tbl[1] = '{32'hFFFF_FFFF, 32'h1, 33'h0_FFFF_FF00, 33'h100};
        tbl[2] = '{32'h0, 32'h0, 33'h0, 33'h0};
        tbl[3] = '{32'h5, 32'h3, 33'h0, 33'h8};
        tbl[4] = '{32'h5, 32'h3, 33'h1_FFFF_FFFF, 33'h1_FFFF_FFF7};
        tbl[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 33'h0, 33'h1_FFFF_FFFE};
        tbl[6] = '{32'h8000_0000, 32'h8000_0000, 33'h1_0000_0001, 33'h1};
        tbl[7] = '{32'd10, 32'd20, 33'd29, 33'd1};
        eds[0] = 1; eds[1] = 5; eds[2] = 2;
        eds[3] = 0; eds[4] = 9; eds[5] = 9;

        rst = 1'b1; start = 1'b0; clear = 1'b0; valid_in = 1'b0;
        a = '0; b = '0; approx_sum = '0;
        cyc(3);
        chk("rst_busy", 64'(busy1), 64'd0);
        chk("rst_done", 64'(done1), 64'd0);
        chk("rst_sample_cnt", 64'(sc1), 64'd0);
        chk("rst_err_cnt", 64'(ec1), 64'd0);
        chk("rst_ed_sum", 64'(es1), 64'd0);
        chk("rst_ed_max", 64'(em1), 64'd0);
        rst = 1'b0;

        // samples offered while idle must be dropped
        valid_in = 1'b1; a = 32'd1; b = 32'd1; approx_sum = 33'd0;
        cyc(3);
        valid_in = 1'b0;
        cyc(3);
        chk("idle_sample_cnt", 64'(sc1), 64'd0);
        chk("idle_busy", 64'(busy1), 64'd0);

        for (int i = 0; i < 8; i++) begin
            restart();
            chk($sformatf("v%0d_busy", i), 64'(busy1), 64'd1);
            valid_in = 1'b1;
            a = tbl[i].a; b = tbl[i].b; approx_sum = tbl[i].ap;
            cyc(1);
            valid_in = 1'b0;
            cyc(1);
            chk($sformatf("v%0d_early_cnt", i), 64'(sc1), 64'd0);
            cyc(1);
            chk($sformatf("v%0d_sample_cnt", i), 64'(sc1), 64'd1);
            chk($sformatf("v%0d_err_cnt", i), 64'(ec1),
                (tbl[i].ed != 0) ? 64'd1 : 64'd0);
            chk($sformatf("v%0d_ed_sum", i), 64'(es1), 64'(tbl[i].ed));
            chk($sformatf("v%0d_ed_max", i), 64'(em1), 64'(tbl[i].ed));
            chk($sformatf("v%0d_done_pre", i), 64'(done1), 64'd0);
            cyc(1);
            chk($sformatf("v%0d_done", i), 64'(done1), 64'd1);
            chk($sformatf("v%0d_hold", i), 64'(sc1), 64'd1);
        end

        // back-to-back run, six offered, four accepted
        restart();
        for (int k = 0; k < 6; k++) begin
            valid_in = 1'b1; a = '0; b = '0;
            approx_sum = 33'(eds[k]);
            cyc(1);
        end
        valid_in = 1'b0;
        chk("b2b_busy_at_last_commit", 64'(busy4), 64'd1);
        chk("b2b_cnt_at_last_commit", 64'(sc4), 64'd4);
        cyc(6);
        chk("b2b_sample_cnt", 64'(sc4), 64'd4);
        chk("b2b_err_cnt", 64'(ec4), 64'd3);
        chk("b2b_ed_sum", 64'(es4), 64'd8);
        chk("b2b_ed_max", 64'(em4), 64'd5);
        chk("b2b_done", 64'(done4), 64'd1);

        // clear beats start in the same cycle
        start = 1'b1; clear = 1'b1;
        cyc(1);
        start = 1'b0; clear = 1'b0;
        chk("prio_busy", 64'(busy4), 64'd0);
        chk("prio_done", 64'(done4), 64'd0);
        chk("prio_sample_cnt", 64'(sc4), 64'd0);
        chk("prio_ed_sum", 64'(es4), 64'd0);
        chk("prio_ed_max", 64'(em4), 64'd0);

        // start during RUN must not wipe the run
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        valid_in = 1'b1; a = '0; b = '0; approx_sum = 33'd3;
        cyc(1);
        start = 1'b1; approx_sum = 33'd4;
        cyc(1);
        start = 1'b0; valid_in = 1'b0;
        cyc(4);
        chk("run_start_sample_cnt", 64'(sc4), 64'd2);
        chk("run_start_ed_sum", 64'(es4), 64'd7);

        // reset right behind an accepted sample discards it
        restart();
        valid_in = 1'b1; a = '0; b = '0; approx_sum = 33'd7;
        cyc(1);
        valid_in = 1'b0; rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        cyc(4);
        chk("abort_sample_cnt", 64'(sc1), 64'd0);
        chk("abort_ed_sum", 64'(es1), 64'd0);
        chk("abort_busy", 64'(busy1), 64'd0);

        // ed = 2^32 per sample; 65537 samples overflow 48 bits
        restart();
        valid_in = 1'b1; a = 32'hFFFF_FFFF; b = 32'h1; approx_sum = '0;
        cyc(65537);
        chk("sat_mid_sample_cnt", 64'(scs), 64'd65535);
        chk("sat_mid_ed_sum", 64'(ess), 64'hFFFF_0000_0000);
        cyc(3);
        valid_in = 1'b0;
        cyc(5);
        chk("sat_ed_sum", 64'(ess), 64'hFFFF_FFFF_FFFF);
        chk("sat_sample_cnt", 64'(scs), 64'd65537);
        chk("sat_err_cnt", 64'(ecs), 64'd65537);
        chk("sat_ed_max", 64'(ems), 64'h1_0000_0000);
        chk("sat_done", 64'(dones), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
